// File: rtl/core_types_pkg.sv
// Core-wide PRF geometry plus the types shared by the PRF read arbitration logic.
package core_types_pkg;

   localparam int unsigned LOG_PR_COUNT          = 7;
   localparam int unsigned PRF_BANK_COUNT        = 4;
   localparam int unsigned LOG_PRF_BANK_COUNT    = 2;
   localparam int unsigned PRF_UPPER_PR_W        = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

   localparam int unsigned PRF_READ_N_REQ        = 4;
   localparam int unsigned PRF_RR_SLOT_COUNT     = 2 * PRF_READ_N_REQ;
   localparam int unsigned LOG_PRF_RR_SLOT_COUNT = $clog2(PRF_RR_SLOT_COUNT);

   typedef struct packed {
      logic                    valid;
      logic [LOG_PR_COUNT-1:0] PR;
   } prf_read_slot_t;

   // Low PR bits select the bank, high bits the row inside it.
   function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PRF_BANK_COUNT-1:0];
   endfunction

   function automatic logic [PRF_UPPER_PR_W-1:0] pr_upper(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
   endfunction

endpackage

// File: rtl/prf_bank_rr_arbiter.sv
// Round-robin pick of one read slot for a single PRF bank; owns the bank's rotating pointer.
module prf_bank_rr_arbiter
   import core_types_pkg::*;
#(
   parameter int unsigned SLOT_COUNT     = PRF_RR_SLOT_COUNT,
   parameter int unsigned LOG_SLOT_COUNT = LOG_PRF_RR_SLOT_COUNT
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [SLOT_COUNT-1:0]     req,
   output logic [SLOT_COUNT-1:0]     grant,
   output logic [LOG_SLOT_COUNT-1:0] winner,
   output logic                      grant_valid
);

   logic [LOG_SLOT_COUNT-1:0] rr_ptr;
   logic [LOG_SLOT_COUNT-1:0] rr_ptr_next;

   // First requesting slot at or after rr_ptr, wrapping modulo SLOT_COUNT.
   always_comb begin
      grant       = '0;
      winner      = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
         if (!grant_valid && req[LOG_SLOT_COUNT'((32'(rr_ptr) + i) % SLOT_COUNT)]) begin
            grant_valid = 1'b1;
            winner      = LOG_SLOT_COUNT'((32'(rr_ptr) + i) % SLOT_COUNT);
         end
      end
      if (grant_valid) begin
         grant[winner] = 1'b1;
      end
   end

   assign rr_ptr_next = (winner == LOG_SLOT_COUNT'(SLOT_COUNT - 1)) ? '0
                                                                   : winner + LOG_SLOT_COUNT'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr <= '0;
      end else if (grant_valid) begin
         rr_ptr <= rr_ptr_next;
      end
   end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares the banked PRF read ports between the IQ operand reads; losers park in a
// one-deep per-slot pending entry and stall their requester until both slots drain.
module prf_read_arbiter
   import core_types_pkg::*;
#(
   parameter int unsigned N_REQ = PRF_READ_N_REQ
) (
   input  logic                                                         CLK,
   input  logic                                                         RST,
   input  logic [N_REQ-1:0][1:0]                                        req_valid_by_rq,
   input  logic [N_REQ-1:0][1:0][LOG_PR_COUNT-1:0]                      req_PR_by_rq,
   output logic [N_REQ-1:0]                                             rq_ready_by_rq,
   output logic [PRF_BANK_COUNT-1:0]                                    bank_read_valid,
   output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_read_upper_PR,
   output logic [N_REQ-1:0][1:0]                                        resp_valid_by_rq,
   output logic [N_REQ-1:0][1:0][LOG_PRF_BANK_COUNT-1:0]                resp_bank_by_rq
);

   localparam int unsigned SLOT_COUNT     = 2 * N_REQ;
   localparam int unsigned LOG_SLOT_COUNT = $clog2(SLOT_COUNT);
   localparam int unsigned CNT_W          = LOG_SLOT_COUNT + 1;

   logic [SLOT_COUNT-1:0]                         req_slot_valid;
   logic [SLOT_COUNT-1:0][LOG_PR_COUNT-1:0]       req_slot_PR;
   logic [SLOT_COUNT-1:0]                         slot_ready;
   logic [SLOT_COUNT-1:0]                         pending_valid;
   logic [SLOT_COUNT-1:0][LOG_PR_COUNT-1:0]       pending_PR;
   prf_read_slot_t [SLOT_COUNT-1:0]               eff_slot;
   logic [SLOT_COUNT-1:0]                         eff_valid;
   logic [SLOT_COUNT-1:0]                         slot_granted;
   logic [SLOT_COUNT-1:0]                         resp_valid;
   logic [SLOT_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0] resp_bank;

   logic [PRF_BANK_COUNT-1:0][SLOT_COUNT-1:0]     bank_req;
   logic [PRF_BANK_COUNT-1:0][SLOT_COUNT-1:0]     bank_grant;
   logic [PRF_BANK_COUNT-1:0][LOG_SLOT_COUNT-1:0] bank_winner;
   logic [PRF_BANK_COUNT-1:0]                     bank_grant_valid;

   // [rq][op] packing is bit-identical to slot = 2*rq + op.
   assign req_slot_valid   = req_valid_by_rq;
   assign req_slot_PR      = req_PR_by_rq;
   assign resp_valid_by_rq = resp_valid;
   assign resp_bank_by_rq  = resp_bank;

   for (genvar r = 0; r < N_REQ; r++) begin : g_ready
      assign rq_ready_by_rq[r] = ~(pending_valid[2*r] | pending_valid[2*r+1]);
   end

   for (genvar s = 0; s < SLOT_COUNT; s++) begin : g_slot
      logic                          pend_v;
      logic [LOG_PR_COUNT-1:0]       pend_pr;
      logic                          rsp_v;
      logic [LOG_PRF_BANK_COUNT-1:0] rsp_b;
      logic [CNT_W-1:0]              wait_cnt;

      assign slot_ready[s] = rq_ready_by_rq[s/2];

      // A parked read always takes precedence; ready gating keeps new requests out meanwhile.
      assign eff_slot[s] = pend_v ? '{valid: 1'b1, PR: pend_pr}
                                  : '{valid: req_slot_valid[s] & slot_ready[s], PR: req_slot_PR[s]};
      assign eff_valid[s] = eff_slot[s].valid;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            pend_v   <= 1'b0;
            pend_pr  <= '0;
            rsp_v    <= 1'b0;
            rsp_b    <= '0;
            wait_cnt <= '0;
         end else begin
            pend_v <= eff_valid[s] & ~slot_granted[s];
            rsp_v  <= slot_granted[s];
            if (eff_valid[s] && !slot_granted[s]) begin
               pend_pr <= eff_slot[s].PR;
            end
            if (slot_granted[s]) begin
               rsp_b <= pr_bank(eff_slot[s].PR);
            end
            if (pend_v && !slot_granted[s]) begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
               wait_cnt <= '0;
            end
         end
      end

      assign pending_valid[s] = pend_v;
      assign pending_PR[s]    = pend_pr;
      assign resp_valid[s]    = rsp_v;
      assign resp_bank[s]     = rsp_b;

      // A parked read must win before every other slot has had a turn on its bank.
      a_fair : assert property (@(posedge CLK) disable iff (RST) wait_cnt < CNT_W'(SLOT_COUNT));
   end

   for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
      for (genvar s = 0; s < SLOT_COUNT; s++) begin : g_match
         assign bank_req[b][s] = eff_slot[s].valid
                               && (pr_bank(eff_slot[s].PR) == LOG_PRF_BANK_COUNT'(b));
      end

      prf_bank_rr_arbiter #(
         .SLOT_COUNT     (SLOT_COUNT),
         .LOG_SLOT_COUNT (LOG_SLOT_COUNT)
      ) u_rr (
         .CLK         (CLK),
         .RST         (RST),
         .req         (bank_req[b]),
         .grant       (bank_grant[b]),
         .winner      (bank_winner[b]),
         .grant_valid (bank_grant_valid[b])
      );

      assign bank_read_valid[b]    = bank_grant_valid[b];
      assign bank_read_upper_PR[b] = bank_grant_valid[b] ? pr_upper(eff_slot[bank_winner[b]].PR)
                                                         : '0;
   end

   // Each slot targets exactly one bank, so at most one grant row can hit it.
   always_comb begin
      slot_granted = '0;
      for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
         slot_granted = slot_granted | bank_grant[LOG_PRF_BANK_COUNT'(b)];
      end
   end

   a_ready_protocol : assert property (@(posedge CLK) disable iff (RST)
                                       (req_slot_valid & ~slot_ready) == '0);

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench: stimulus pushes expected responses into a scoreboard that a negedge monitor drains.
module tb_prf_read_arbiter;
   import core_types_pkg::*;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [3:0][1:0]      req_valid_by_rq;
   logic [3:0][1:0][6:0] req_PR_by_rq;
   logic [3:0]           rq_ready_by_rq;
   logic [3:0]           bank_read_valid;
   logic [3:0][4:0]      bank_read_upper_PR;
   logic [3:0][1:0]      resp_valid_by_rq;
   logic [3:0][1:0][1:0] resp_bank_by_rq;

   always #5 CLK = ~CLK;

   prf_read_arbiter #(.N_REQ(4)) dut (
      .CLK                (CLK),
      .RST                (RST),
      .req_valid_by_rq    (req_valid_by_rq),
      .req_PR_by_rq       (req_PR_by_rq),
      .rq_ready_by_rq     (rq_ready_by_rq),
      .bank_read_valid    (bank_read_valid),
      .bank_read_upper_PR (bank_read_upper_PR),
      .resp_valid_by_rq   (resp_valid_by_rq),
      .resp_bank_by_rq    (resp_bank_by_rq)
   );

   typedef struct {
      int          cyc;
      logic [7:0]  vld;
      logic [15:0] bank;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_req();
      req_valid_by_rq = '0;
      req_PR_by_rq    = '0;
   endtask

   task automatic issue(input logic [1:0] r, input logic op, input logic [6:0] pr);
      req_valid_by_rq[r][op] = 1'b1;
      req_PR_by_rq[r][op]    = pr;
   endtask

   // Expected response for a slot granted this cycle shows up next cycle.
   task automatic expect_resp(input logic [2:0] slot, input logic [1:0] bank);
      exp_t e;
      int   n;
      n = exp_q.size();
      if (n > 0 && exp_q[n-1].cyc == cyc + 1) begin
         e = exp_q[n-1];
         void'(exp_q.pop_back());
      end else begin
         e.cyc  = cyc + 1;
         e.vld  = '0;
         e.bank = '0;
      end
      e.vld[slot]                = 1'b1;
      e.bank[{slot, 1'b0} +: 2]  = bank;
      exp_q.push_back(e);
   endtask

   task automatic chk_ready(input string name, input logic [3:0] e);
      check({name, "_ready"}, 32'(rq_ready_by_rq), 32'(e));
   endtask

   task automatic chk_brv(input string name, input logic [3:0] e);
      check({name, "_bank_read_valid"}, 32'(bank_read_valid), 32'(e));
   endtask

   task automatic chk_upper(input string name, input logic [1:0] b, input logic [4:0] e);
      check({name, "_upper_PR"}, 32'(bank_read_upper_PR[b]), 32'(e));
   endtask

   // Scoreboard monitor
   logic [7:0]  mon_dv;
   logic [15:0] mon_db;
   logic [15:0] mon_mask;
   exp_t        mon_e;

   always @(negedge CLK) begin
      if (!RST) begin
         mon_dv = resp_valid_by_rq;
         mon_db = resp_bank_by_rq;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL resp_missed: got no response, expected vld %0h at cycle %0d",
                     exp_q[0].vld, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            for (int s = 0; s < 8; s++) mon_mask[2*s +: 2] = {2{mon_e.vld[s]}};
            check("resp_valid", 32'(mon_dv), 32'(mon_e.vld));
            check("resp_bank", 32'(mon_db & mon_mask), 32'(mon_e.bank));
         end else if (mon_dv != '0) begin
            check("resp_unexpected", 32'(mon_dv), 32'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int issue_cyc[8];
   int issued;
   int grants;
   int k;

   initial begin
      RST = 1'b1;
      clear_req();
      repeat (2) @(posedge CLK);
      #1;
      chk_ready("reset", 4'b1111);
      chk_brv("reset", 4'b0000);
      check("reset_resp_valid", 32'(resp_valid_by_rq), 32'(0));
      RST = 1'b0;

      // single read: rq1 A, PR 0x0D -> bank 1, row 3
      step();
      issue(2'd1, 1'b0, 7'h0D);
      #1;
      chk_ready("single", 4'b1111);
      chk_brv("single", 4'b0010);
      chk_upper("single", 2'd1, 5'd3);
      expect_resp(3'd2, 2'd1);
      step();
      clear_req();
      #1;
      chk_brv("single_idle", 4'b0000);

      // conflict on bank 2: slot 0 then slot 5
      step();
      issue(2'd0, 1'b0, 7'h0A);
      issue(2'd2, 1'b1, 7'h16);
      #1;
      chk_ready("conflict_c0", 4'b1111);
      chk_brv("conflict_c0", 4'b0100);
      chk_upper("conflict_c0", 2'd2, 5'd2);
      expect_resp(3'd0, 2'd2);
      step();
      clear_req();
      #1;
      chk_ready("conflict_c1", 4'b1011);
      chk_brv("conflict_c1", 4'b0100);
      chk_upper("conflict_c1", 2'd2, 5'd5);
      expect_resp(3'd5, 2'd2);
      step();
      #1;
      chk_ready("conflict_c2", 4'b1111);
      chk_brv("conflict_c2", 4'b0000);

      // bank 2 pointer now 6: slot 6 beats slot 0
      step();
      issue(2'd0, 1'b0, 7'h0A);
      issue(2'd3, 1'b0, 7'h1E);
      #1;
      chk_brv("rrptr_c0", 4'b0100);
      chk_upper("rrptr_c0", 2'd2, 5'd7);
      expect_resp(3'd6, 2'd2);
      step();
      clear_req();
      #1;
      chk_ready("rrptr_c1", 4'b1110);
      chk_upper("rrptr_c1", 2'd2, 5'd2);
      expect_resp(3'd0, 2'd2);
      step();
      #1;
      chk_ready("rrptr_c2", 4'b1111);

      // same-requester collision on bank 0
      step();
      issue(2'd3, 1'b0, 7'h04);
      issue(2'd3, 1'b1, 7'h08);
      #1;
      chk_ready("samerq_c0", 4'b1111);
      chk_brv("samerq_c0", 4'b0001);
      chk_upper("samerq_c0", 2'd0, 5'd1);
      expect_resp(3'd6, 2'd0);
      step();
      clear_req();
      #1;
      chk_ready("samerq_c1", 4'b0111);
      chk_brv("samerq_c1", 4'b0001);
      chk_upper("samerq_c1", 2'd0, 5'd2);
      expect_resp(3'd7, 2'd0);
      step();
      #1;
      chk_ready("samerq_c2", 4'b1111);
      chk_brv("samerq_c2", 4'b0000);

      // fairness: every slot hammers bank 3, row = slot index
      issued = 0;
      grants = 0;
      for (k = 0; k < 16; k++) begin
         step();
         clear_req();
         for (int r = 0; r < 4; r++) begin
            if (rq_ready_by_rq[r]) begin
               issue(2'(r), 1'b0, {2'b00, 3'(2*r), 2'b11});
               issue(2'(r), 1'b1, {2'b00, 3'(2*r+1), 2'b11});
               issue_cyc[2*r]   = cyc;
               issue_cyc[2*r+1] = cyc;
               issued += 2;
            end
         end
         #1;
         chk_brv("fair", 4'b1000);
         chk_upper("fair", 2'd3, 5'(k % 8));
         check("fair_wait_gt8", 32'((cyc - issue_cyc[k % 8]) > 8), 32'(0));
         expect_resp(3'(k % 8), 2'd3);
         grants++;
      end
      for (k = 16; k < 32; k++) begin
         step();
         clear_req();
         #1;
         if (!bank_read_valid[3]) break;
         chk_upper("fair_drain", 2'd3, 5'(k % 8));
         check("fair_wait_gt8", 32'((cyc - issue_cyc[k % 8]) > 8), 32'(0));
         expect_resp(3'(k % 8), 2'd3);
         grants++;
      end
      chk_brv("fair_drained", 4'b0000);
      check("fair_grant_count", 32'(grants), 32'(issued));
      chk_ready("fair_drained", 4'b1111);

      // parallel banks
      step();
      issue(2'd0, 1'b0, 7'h10);
      issue(2'd1, 1'b0, 7'h25);
      issue(2'd2, 1'b0, 7'h3A);
      issue(2'd3, 1'b0, 7'h7F);
      #1;
      chk_ready("parallel", 4'b1111);
      chk_brv("parallel", 4'b1111);
      chk_upper("parallel_b0", 2'd0, 5'd4);
      chk_upper("parallel_b1", 2'd1, 5'd9);
      chk_upper("parallel_b2", 2'd2, 5'd14);
      chk_upper("parallel_b3", 2'd3, 5'd31);
      expect_resp(3'd0, 2'd0);
      expect_resp(3'd2, 2'd1);
      expect_resp(3'd4, 2'd2);
      expect_resp(3'd6, 2'd3);
      step();
      clear_req();
      #1;
      chk_ready("parallel_next", 4'b1111);
      chk_brv("parallel_next", 4'b0000);

      // mid-stream reset with slots 0 and 2 parked on bank 1 (pointer 3)
      step();
      issue(2'd0, 1'b0, 7'h01);
      issue(2'd1, 1'b0, 7'h05);
      issue(2'd2, 1'b0, 7'h09);
      #1;
      chk_brv("midrst_c0", 4'b0010);
      chk_upper("midrst_c0", 2'd1, 5'd2);
      expect_resp(3'd4, 2'd1);
      step();
      clear_req();
      #1;
      chk_ready("midrst_c1", 4'b1100);
      chk_brv("midrst_c1", 4'b0010);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      #1;
      chk_ready("in_reset", 4'b1111);
      chk_brv("in_reset", 4'b0000);
      check("in_reset_resp_valid", 32'(resp_valid_by_rq), 32'(0));
      step();
      chk_ready("in_reset_edge", 4'b1111);
      chk_brv("in_reset_edge", 4'b0000);
      check("in_reset_edge_resp_valid", 32'(resp_valid_by_rq), 32'(0));
      RST = 1'b0;
      issue(2'd2, 1'b0, 7'h0D);
      #1;
      chk_ready("post_reset", 4'b1111);
      chk_brv("post_reset", 4'b0010);
      chk_upper("post_reset", 2'd1, 5'd3);
      expect_resp(3'd4, 2'd1);
      step();
      clear_req();
      #1;
      chk_brv("post_reset_idle", 4'b0000);
      chk_ready("post_reset_idle", 4'b1111);

      step();
      step();
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
